// File: rtl/riscv_pkg.sv
// Shared encodings for the writeback stage: wb_sel mux codes, load funct3
// codes and the held WB register layout.
package riscv_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_IMM  = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        ecall;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    wb_sel_e     wb_sel;
    logic [31:0] alu;
    logic [31:0] load_raw;
    logic [31:0] pc4;
    logic [31:0] imm;
  } wb_reg_t;

  function automatic wb_reg_t wb_reset_value(logic [31:0] pc4);
    wb_reg_t r;
    r     = '0;
    r.pc4 = pc4;
    return r;
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// MEM-to-WB pipeline bundle; the MEM stage is the master, wb_stage the slave.
interface wb_stage_if;
  logic        m_valid;
  logic        m_reg_write;
  logic        m_ecall;
  logic [4:0]  m_rd;
  logic [2:0]  m_funct3;
  logic [1:0]  m_wb_sel;
  logic [31:0] m_alu;
  logic [31:0] m_load_raw;
  logic [31:0] m_pc4;
  logic [31:0] m_imm;

  modport master (
    output m_valid, m_reg_write, m_ecall, m_rd, m_funct3, m_wb_sel,
           m_alu, m_load_raw, m_pc4, m_imm
  );

  modport slave (
    input  m_valid, m_reg_write, m_ecall, m_rd, m_funct3, m_wb_sel,
           m_alu, m_load_raw, m_pc4, m_imm
  );
endinterface

// File: rtl/wb_stage_load_extend.sv
// Combinational load extraction: picks byte/halfword from the aligned word
// by address offset and sign- or zero-extends according to funct3.
module load_extend
  import riscv_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = raw[7:0];
    case (offset)
      2'd0: byte_val = raw[7:0];
      2'd1: byte_val = raw[15:8];
      2'd2: byte_val = raw[23:16];
      2'd3: byte_val = raw[31:24];
      default: byte_val = raw[7:0];
    endcase
    half_val = offset[1] ? raw[31:16] : raw[15:0];

    result = raw;
    case (funct3)
      F3_LB:   result = {{24{byte_val[7]}}, byte_val};
      F3_LBU:  result = {24'h0, byte_val};
      F3_LH:   result = {{16{half_val[15]}}, half_val};
      F3_LHU:  result = {16'h0, half_val};
      F3_LW:   result = raw;
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback pipeline register with result mux and sticky halt.
// Optional macro WB_INSTRET_EN adds a 64-bit retired-instruction counter.
module wb_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC4 = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  wb_stage_if.slave   mem,
  input  logic        halt_in,
  output logic        wb_en,
  output logic [4:0]  rd_index,
  output logic [31:0] wb_data,
  output logic        ecall_sig,
  output logic        wb_valid,
  output logic        halted
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0] instret
`endif
);

  wb_reg_t     held;
  logic [31:0] load_val;

  // Halting freezes the register; the halting edge itself still captures.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held   <= wb_reset_value(RESET_PC4);
      halted <= 1'b0;
    end else if (!halted) begin
      if (ecall_sig && halt_in) halted <= 1'b1;
      if (!stall) begin
        held.valid     <= mem.m_valid & ~flush;
        held.reg_write <= mem.m_reg_write;
        held.ecall     <= mem.m_ecall;
        held.rd        <= mem.m_rd;
        held.funct3    <= mem.m_funct3;
        held.wb_sel    <= wb_sel_e'(mem.m_wb_sel);
        held.alu       <= mem.m_alu;
        held.load_raw  <= mem.m_load_raw;
        held.pc4       <= mem.m_pc4;
        held.imm       <= mem.m_imm;
      end
    end
  end

  load_extend u_load_extend (
    .raw    (held.load_raw),
    .offset (held.alu[1:0]),
    .funct3 (held.funct3),
    .result (load_val)
  );

  always_comb begin
    wb_data = held.alu;
    case (held.wb_sel)
      WB_ALU:  wb_data = held.alu;
      WB_LOAD: wb_data = load_val;
      WB_PC4:  wb_data = held.pc4;
      WB_IMM:  wb_data = held.imm;
      default: wb_data = held.alu;
    endcase
  end

  assign rd_index  = held.rd;
  assign wb_valid  = held.valid & ~halted;
  assign ecall_sig = held.valid & held.ecall & ~halted;
  assign wb_en     = held.valid & held.reg_write & (held.rd != 5'd0) & ~halted;

`ifdef WB_INSTRET_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        instret <= '0;
    else if (wb_valid) instret <= instret + 64'd1;
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a field-level model checked every cycle,
// plus hand-computed literal expectations at key points.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, halt_in;
  logic        wb_en, ecall_sig, wb_valid, halted;
  logic [4:0]  rd_index;
  logic [31:0] wb_data;
`ifdef WB_INSTRET_EN
  logic [63:0] instret;
`endif

  wb_stage_if mif ();

  wb_stage #(.RESET_PC4(32'h0000_0004)) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .flush     (flush),
    .mem       (mif),
    .halt_in   (halt_in),
    .wb_en     (wb_en),
    .rd_index  (rd_index),
    .wb_data   (wb_data),
    .ecall_sig (ecall_sig),
    .wb_valid  (wb_valid),
    .halted    (halted)
`ifdef WB_INSTRET_EN
    ,
    .instret   (instret)
`endif
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the instruction currently sitting in WB, as plain fields.
  typedef struct {
    bit        v, rw, ec;
    bit [4:0]  rd;
    bit [2:0]  f3;
    bit [1:0]  sel;
    bit [31:0] alu, raw, pc4, imm;
  } ins_t;

  ins_t            q;
  bit              mh;
  longint unsigned mret;

  function automatic bit [31:0] ld(bit [31:0] raw, bit [1:0] off, bit [2:0] f3);
    bit [31:0] b, h;
    b = raw >> (8 * off);
    h = off[1] ? (raw >> 16) : raw;
    case (f3)
      3'd0: return 32'($signed(b[7:0]));
      3'd4: return {24'h0, b[7:0]};
      3'd1: return 32'($signed(h[15:0]));
      3'd5: return {16'h0, h[15:0]};
      default: return raw;
    endcase
  endfunction

  function automatic bit [31:0] exp_data(ins_t i);
    case (i.sel)
      2'd0: return i.alu;
      2'd1: return ld(i.raw, i.alu[1:0], i.f3);
      2'd2: return i.pc4;
      default: return i.imm;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q = '{default: 0};
      q.pc4 = 32'h4;
      mh = 0;
      mret = 0;
    end else if (!mh) begin
      if (q.v) mret++;
      if (q.v && q.ec && halt_in) mh = 1;
      if (!stall) begin
        q.v   = mif.m_valid & ~flush;
        q.rw  = mif.m_reg_write;
        q.ec  = mif.m_ecall;
        q.rd  = mif.m_rd;
        q.f3  = mif.m_funct3;
        q.sel = mif.m_wb_sel;
        q.alu = mif.m_alu;
        q.raw = mif.m_load_raw;
        q.pc4 = mif.m_pc4;
        q.imm = mif.m_imm;
      end
    end
  end

  always @(negedge clk) begin
    check("wb_valid",  wb_valid,  q.v & ~mh);
    check("wb_en",     wb_en,     q.v & q.rw & (q.rd != 0) & ~mh);
    check("ecall_sig", ecall_sig, q.v & q.ec & ~mh);
    check("rd_index",  rd_index,  q.rd);
    check("wb_data",   wb_data,   exp_data(q));
    check("halted",    halted,    mh);
`ifdef WB_INSTRET_EN
    check("instret",   instret,   mret);
`endif
  end

  task automatic put(input bit v, input bit rw, input bit ec, input bit [4:0] rd,
                     input bit [2:0] f3, input bit [1:0] sel, input bit [31:0] alu,
                     input bit [31:0] raw, input bit [31:0] pc4, input bit [31:0] imm);
    mif.m_valid = v; mif.m_reg_write = rw; mif.m_ecall = ec; mif.m_rd = rd;
    mif.m_funct3 = f3; mif.m_wb_sel = sel; mif.m_alu = alu;
    mif.m_load_raw = raw; mif.m_pc4 = pc4; mif.m_imm = imm;
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wb_valid"}, wb_valid, 1'b0);
    check({tag, "_wb_en"},    wb_en,    1'b0);
    check({tag, "_ecall"},    ecall_sig, 1'b0);
    check({tag, "_wb_data"},  wb_data,  32'h0);
    check({tag, "_halted"},   halted,   1'b0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; halt_in = 1'b0;
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 reset = 1'b0;
    #1 check_reset_outputs("rst0");
    @(negedge clk);
    #2 reset = 1'b1;

    put(1, 1, 0, 5, 3'd2, 2'd0, 32'h1234_5678, 32'h0, 32'h100, 32'h0);
    cyc();
    check("alu_wb_en", wb_en, 1'b1);
    check("alu_rd", rd_index, 5'd5);
    check("alu_data", wb_data, 32'h1234_5678);

    put(1, 1, 0, 6, 3'd0, 2'd1, 32'h2, 32'h0080_0000, 32'h0, 32'h0);
    cyc();
    check("lb_data", wb_data, 32'hFFFF_FF80);
    put(1, 1, 0, 6, 3'd4, 2'd1, 32'h2, 32'h0080_0000, 32'h0, 32'h0);
    cyc();
    check("lbu_data", wb_data, 32'h0000_0080);
    put(1, 1, 0, 6, 3'd1, 2'd1, 32'h2, 32'h8001_0000, 32'h0, 32'h0);
    cyc();
    check("lh_data", wb_data, 32'hFFFF_8001);
    put(1, 1, 0, 6, 3'd5, 2'd1, 32'h2, 32'h8001_0000, 32'h0, 32'h0);
    cyc();
    check("lhu_data", wb_data, 32'h0000_8001);
    put(1, 1, 0, 6, 3'd0, 2'd1, 32'h3, 32'h7F00_00FF, 32'h0, 32'h0);
    cyc();
    check("lb_off3", wb_data, 32'h0000_007F);
    put(1, 1, 0, 6, 3'd1, 2'd1, 32'h0, 32'h1234_F00D, 32'h0, 32'h0);
    cyc();
    put(1, 1, 0, 6, 3'd2, 2'd1, 32'h1, 32'hDEAD_BEEF, 32'h0, 32'h0);
    cyc();
    check("lw_data", wb_data, 32'hDEAD_BEEF);
    put(1, 1, 0, 6, 3'd3, 2'd1, 32'h0, 32'hCAFE_0080, 32'h0, 32'h0);
    cyc();
    put(1, 1, 0, 7, 3'd0, 2'd2, 32'h0, 32'h0, 32'h0000_1004, 32'h0);
    cyc();
    check("pc4_data", wb_data, 32'h0000_1004);
    put(1, 1, 0, 8, 3'd0, 2'd3, 32'h0, 32'h0, 32'h0, 32'hFFFF_F800);
    cyc();
    check("imm_data", wb_data, 32'hFFFF_F800);

    put(1, 1, 0, 0, 3'd0, 2'd0, 32'h55, 32'h0, 32'h0, 32'h0);
    cyc();
    check("rd0_wb_en", wb_en, 1'b0);
    check("rd0_valid", wb_valid, 1'b1);

    flush = 1'b1;
    put(1, 1, 0, 3, 3'd0, 2'd0, 32'h77, 32'h0, 32'h0, 32'h0);
    cyc();
    check("flush_valid", wb_valid, 1'b0);
    flush = 1'b0;

    put(1, 1, 0, 7, 3'd0, 2'd0, 32'hAAAA, 32'h0, 32'h0, 32'h0);
    cyc();
    stall = 1'b1; flush = 1'b1;
    put(1, 1, 0, 9, 3'd0, 2'd3, 32'hBBBB, 32'h0, 32'h0, 32'h1111);
    cyc();
    check("stall_rd", rd_index, 5'd7);
    check("stall_data", wb_data, 32'hAAAA);
    check("stall_valid", wb_valid, 1'b1);
    flush = 1'b0;
    cyc();
    stall = 1'b0;

    put(1, 0, 1, 0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    cyc();
    check("print_ecall", ecall_sig, 1'b1);
    put(1, 1, 0, 4, 3'd0, 2'd0, 32'h44, 32'h0, 32'h0, 32'h0);
    cyc();
    check("print_nohalt", halted, 1'b0);
    check("print_next_en", wb_en, 1'b1);

    stall = 1'b1;
    cyc();
    #1 reset = 1'b0;
    #1 check_reset_outputs("rst_stall");
    @(negedge clk);
    #2 reset = 1'b1; stall = 1'b0;

    for (int unsigned i = 0; i < 9; i++) begin
      put(1, 1, 0, 5'(i + 1), 3'd0, 2'd0, 32'(i * 3), 32'h0, 32'h0, 32'h0);
      cyc();
    end
    for (int unsigned i = 0; i < 3; i++) begin
      put(0, 1, 0, 2, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
      cyc();
    end
    put(1, 0, 1, 0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    cyc();
    check("halt_ecall", ecall_sig, 1'b1);
    halt_in = 1'b1;
    put(1, 1, 0, 9, 3'd0, 2'd0, 32'h55, 32'h0, 32'h0, 32'h0);
    cyc();
    check("halted_set", halted, 1'b1);
    check("halted_en", wb_en, 1'b0);
    check("halted_ecall", ecall_sig, 1'b0);
    halt_in = 1'b0;
    put(1, 1, 1, 12, 3'd0, 2'd3, 32'h66, 32'h0, 32'h0, 32'h9999);
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0; stall = 1'b1;
    cyc();
    stall = 1'b0;
    cyc();
    check("frozen_rd", rd_index, 5'd9);
    check("frozen_data", wb_data, 32'h55);
    check("frozen_valid", wb_valid, 1'b0);
    check("frozen_en", wb_en, 1'b0);
`ifdef WB_INSTRET_EN
    check("instret_10", instret, 64'd10);
`endif

    #1 reset = 1'b0;
    #1 check_reset_outputs("rst_halt");
    @(negedge clk);
    #2 reset = 1'b1;
    put(1, 1, 0, 3, 3'd0, 2'd0, 32'hF00D, 32'h0, 32'h0, 32'h0);
    cyc();
    check("post_rst_en", wb_en, 1'b1);
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter: RESET_PC4, 32'h0000_0004, reset value of the held PC+4 field.
REQ-002 SHALL have port: clk  in  1  pipeline clock, all state on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-low; clears all state.
REQ-004 SHALL have port: stall  in  1  hold the WB register contents.
REQ-005 SHALL have port: flush  in  1  load a bubble (valid=0) into the WB register.
REQ-006 SHALL have ports: m_valid in 1, m_reg_write in 1, m_ecall in 1, m_rd in 5, m_funct3 in 3, m_wb_sel in 2; MEM-stage control.
REQ-007 SHALL have ports: m_alu in 32, m_load_raw in 32, m_pc4 in 32, m_imm in 32; MEM-stage data (m_load_raw is the aligned memory word).
REQ-008 SHALL have port: halt_in  in  1  halt request from the register file.
REQ-009 SHALL have outputs: wb_en 1, rd_index 5, wb_data 32, ecall_sig 1; the register-file write/ecall port.
REQ-010 SHALL have outputs: wb_valid 1 (WB holds a live instruction), halted 1 (sticky stop).

Function
REQ-011 Rising edge, stall=0, flush=0: capture all m_* fields into the WB register; single-cycle latency.
REQ-012 stall=1: WB register unchanged; stall has priority over flush.
REQ-013 flush=1, stall=0: capture with valid forced to 0.
REQ-014 wb_data mux on held wb_sel: 00 ALU, 01 LOAD, 10 PC+4, 11 IMM.
REQ-015 LOAD extraction uses held alu[1:0]: funct3 000 lb / 100 lbu select byte alu[1:0], sign-/zero-extended; 001 lh / 101 lhu select halfword alu[1], sign-/zero-extended; 010 lw and all other codes return the full word.
REQ-016 wb_en = valid & reg_write & (rd_index != 0) & ~halted; combinational from the WB register.
REQ-017 ecall_sig = valid & ecall & ~halted.
REQ-018 halted sets on the edge where ecall_sig=1 and halt_in=1; stays set until reset.
REQ-019 With halted=1: wb_en=0, ecall_sig=0, WB register frozen regardless of stall/flush.
REQ-020 ecall with halt_in=0 (print request): no halt, instruction retires normally.
REQ-021 wb_valid reflects the held valid bit, forced 0 when halted.

Reset
REQ-022 Reset low: valid=0, reg_write=0, ecall=0, rd=0, wb_sel=00, all data fields 0 except pc4=RESET_PC4, halted=0.
REQ-023 Consequently wb_en=0, ecall_sig=0, wb_valid=0, wb_data=0 during reset; reset mid-stall or mid-halt returns to this state immediately.

Configuration
REQ-024 Macro WB_INSTRET_EN: when defined, adds output instret (64) counting cycles with wb_valid=1 and ~halted, reset to 0, wraps 2^64-1 -> 0; frozen when halted.
REQ-025 Without WB_INSTRET_EN: no instret port, no counter logic.

Structure
REQ-026 Shared package riscv_pkg SHALL hold wb_sel encodings (WB_ALU, WB_LOAD, WB_PC4, WB_IMM) and load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
REQ-027 Load extraction SHALL be sub-module load_extend (combinational: raw word, offset, funct3 -> 32-bit result).

Verification
REQ-028 m_valid=1, reg_write=1, rd=5, wb_sel=00, alu=32'h1234_5678 -> next cycle wb_en=1, rd_index=5, wb_data=32'h1234_5678.
REQ-029 wb_sel=01, funct3=000, alu[1:0]=2, raw=32'h0080_0000 -> wb_data=32'hFFFF_FF80; funct3=100 -> 32'h0000_0080; funct3=001, alu[1]=1, raw=32'h8001_0000 -> 32'hFFFF_8001.
REQ-030 rd=0 with reg_write=1 -> wb_en=0; flush=1 with stall=0 -> wb_valid=0 next cycle; stall=1 with flush=1 -> WB contents unchanged.
REQ-031 m_ecall=1, halt_in=1 -> ecall_sig=1 one cycle, then halted=1, wb_en=0 for all later inputs; halt_in=0 -> halted stays 0.
REQ-032 WB_INSTRET_EN defined: 10 valid instructions, 3 bubbles, then halt -> instret=10 and held; reset low mid-sequence -> all outputs return to REQ-022/023 values asynchronously.
